// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issue sequencer.
// Accepts an op from ID/EX and holds it on the ALU port until the ALU signals completion.
// Multi-cycle ops are followed by a one-cycle idle gap so that the multiplier/divider restarts.
// The result is then held for EX/MEM until it is taken.
module alu_issue_ctrl #(
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned TIMEOUT = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [4:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [4:0]       alu_ctrl,
  output logic             alu_en,
  input  logic             alu_compl,
  input  logic [63:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [7:0]       out_lat,
  output logic             busy
);

  // Multi-cycle op codes, matching the common package encoding.
  localparam logic [4:0] OpMul   = 5'd10;
  localparam logic [4:0] OpMulw  = 5'd11;
  localparam logic [4:0] OpDiv   = 5'd12;
  localparam logic [4:0] OpDivu  = 5'd13;
  localparam logic [4:0] OpRem   = 5'd14;
  localparam logic [4:0] OpRemu  = 5'd15;
  localparam logic [4:0] OpDivw  = 5'd16;
  localparam logic [4:0] OpDivuw = 5'd17;
  localparam logic [4:0] OpRemw  = 5'd18;
  localparam logic [4:0] OpRemuw = 5'd19;

  // The counter is at least 8 bits wide so that the latency saturation compare is always legal.
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e            state_q, state_d;
  logic [63:0]       a_q, b_q;
  logic [4:0]        ctrl_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [63:0]       res_q, res_d;
  logic [TAG_W-1:0]  otag_q, otag_d;
  logic              err_q, err_d;
  logic [7:0]        lat_q, lat_d;
  logic              mc, accept, timeout;
  logic [CntW-1:0]   run_len;
  logic [7:0]        run_lat;

  // Classify the latched op as multi-cycle.
  always_comb begin
    case (ctrl_q)
      OpMul, OpMulw, OpDiv, OpDivu, OpRem, OpRemu,
      OpDivw, OpDivuw, OpRemw, OpRemuw: mc = 1'b1;
      default:                          mc = 1'b0;
    endcase
  end

  // run_len counts the current RUN cycle, so it is 1 in the first RUN cycle.
  assign run_len = cnt_q + CntW'(1);
  assign run_lat = (run_len > CntW'(255)) ? 8'hff : run_len[7:0];
  assign timeout = (run_len == CntW'(TIMEOUT));

  // Next-state, handshake and output-register update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    res_d    = res_q;
    otag_d   = otag_q;
    err_d    = err_q;
    lat_d    = lat_q;
    in_ready = 1'b0;
    alu_en   = 1'b0;
    accept   = 1'b0;

    if (ov_q && out_ready) ov_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = !flush && (!ov_q || out_ready);
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        alu_en = mc;
        cnt_d  = run_len;
        if (flush) begin
          state_d = mc ? StGap : StIdle;
        end else if (alu_compl) begin
          // Completion wins over a timeout landing in the same cycle.
          ov_d    = 1'b1;
          res_d   = alu_result;
          otag_d  = tag_q;
          err_d   = 1'b0;
          lat_d   = run_lat;
          state_d = mc ? StGap : StIdle;
        end else if (timeout) begin
          ov_d    = 1'b1;
          res_d   = 64'hdeadbeefdeadbeef;
          otag_d  = tag_q;
          err_d   = 1'b1;
          lat_d   = run_lat;
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush) ov_d = 1'b0;
  end

  // State, counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      otag_q  <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  // Operand/ctrl/tag latch; these registers hold across RUN, GAP and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      tag_q  <= '0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      ctrl_q <= in_ctrl;
      tag_q  <= in_tag;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_tag    = otag_q;
  assign out_err    = err_q;
  assign out_lat    = lat_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed vector table, hand sequences, randomized scoreboard.
module tb_alu_issue_ctrl;

  localparam int Tmo = 127;

  localparam logic [4:0] CAdd = 5'd0, CSub = 5'd1, CAnd = 5'd2, COr = 5'd3, CXor = 5'd4;
  localparam logic [4:0] CMul = 5'd10, CMulw = 5'd11, CDiv = 5'd12, CDivu = 5'd13;
  localparam logic [4:0] CRem = 5'd14, CRemu = 5'd15, CDivw = 5'd16, CDivuw = 5'd17;
  localparam logic [4:0] CRemw = 5'd18, CRemuw = 5'd19;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_ctrl;
  logic [7:0]  in_tag;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_ctrl;
  logic        alu_en, alu_compl;
  logic        out_valid, out_ready, out_err, busy;
  logic [63:0] out_result;
  logic [7:0]  out_tag, out_lat;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl #(.TAG_W(8), .TIMEOUT(Tmo)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_ctrl(in_ctrl), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
    .alu_compl(alu_compl), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .out_lat(out_lat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_mc(input logic [4:0] c);
    return c inside {CMul, CMulw, CDiv, CDivu, CRem, CRemu, CDivw, CDivuw, CRemw, CRemuw};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural ALU result, used both by the ALU stand-in and the scoreboard.
  function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [63:0] a,
                                         input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] swa, swb;
    logic [63:0] r;
    sa = a; sb = b; swa = a[31:0]; swb = b[31:0];
    r = '0;
    case (c)
      CAdd:   r = a + b;
      CSub:   r = a - b;
      CAnd:   r = a & b;
      COr:    r = a | b;
      CXor:   r = a ^ b;
      CMul:   r = a * b;
      CMulw:  r = sext32(a[31:0] * b[31:0]);
      CDiv:   if (b == 0) r = '1; else r = sa / sb;
      CDivu:  if (b == 0) r = '1; else r = a / b;
      CRem:   if (b == 0) r = a; else r = sa % sb;
      CRemu:  if (b == 0) r = a; else r = a % b;
      CDivw:  if (swb == 0) r = '1; else r = sext32(swa / swb);
      CDivuw: if (swb == 0) r = '1; else r = sext32(a[31:0] / b[31:0]);
      CRemw:  if (swb == 0) r = sext32(a[31:0]); else r = sext32(swa % swb);
      CRemuw: if (swb == 0) r = sext32(a[31:0]); else r = sext32(a[31:0] % b[31:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // ALU stand-in: single-cycle ops complete at once, multi-cycle ops on the alu_k-th en cycle.
  int en_cnt = 0;
  int alu_k  = 1;
  bit alu_stuck = 1'b0;

  always @(posedge clk) begin
    if (reset || !alu_en) en_cnt <= 0;
    else                  en_cnt <= en_cnt + 1;
  end

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_compl  = 1'b0;
    if (!alu_stuck) begin
      if (is_mc(alu_ctrl)) alu_compl = alu_en && (en_cnt == alu_k - 1);
      else                 alu_compl = 1'b1;
    end
  end

  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    int          k;
    bit          stuck;
    logic [63:0] res;
    int          lat;
    bit          err;
    int          en;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  tag;
    logic [7:0]  lat;
  } exp_t;

  // Issue one op with out_ready high and check its result, latency and handshake timing.
  task automatic run_vec(input vec_t v, input logic [7:0] tag);
    int waitc, en_cycles, seen_at;
    bit mcv;
    alu_k = v.k; alu_stuck = v.stuck; mcv = is_mc(v.ctrl);
    in_a = v.a; in_b = v.b; in_ctrl = v.ctrl; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 8) begin
      @(posedge clk); #1;
      @(negedge clk);
      waitc++;
    end
    chk("vec accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    en_cycles = 0; seen_at = 0;
    for (int c = 1; c <= Tmo + 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen_at = c;
        break;
      end
      if (alu_en) en_cycles++;
      @(posedge clk); #1;
    end
    chk("vec out_valid cycle", seen_at, v.lat + 1);
    chk("vec result", out_result, v.res);
    chk("vec tag", out_tag, tag);
    chk("vec lat", out_lat, v.lat);
    chk("vec err", out_err, v.err);
    chk("vec en cycles", en_cycles, v.en);
    chk("vec en low at valid", alu_en, 1'b0);
    chk("vec in_ready at valid", in_ready, !mcv);
    @(posedge clk); #1;
    alu_stuck = 1'b0;
  endtask

  vec_t vecs[9];
  exp_t sb[$];
  exp_t e;
  logic [4:0] ops[15];
  int  pend_k;
  bit  acc;
  int  ov_bad;

  initial begin
    vecs[0] = '{CAdd,  64'd3,   64'd4,  0,   1'b0, 64'd7,  1,   1'b0, 0};
    vecs[1] = '{CDiv,  64'd100, 64'd7,  65,  1'b0, 64'd14, 65,  1'b0, 65};
    vecs[2] = '{CSub,  64'd10,  64'd3,  0,   1'b0, 64'd7,  1,   1'b0, 0};
    vecs[3] = '{CMul,  64'd6,   64'd7,  3,   1'b0, 64'd42, 3,   1'b0, 3};
    vecs[4] = '{CRemu, 64'd100, 64'd7,  5,   1'b0, 64'd2,  5,   1'b0, 5};
    vecs[5] = '{CDivu, 64'd50,  64'd5,  1,   1'b0, 64'd10, 1,   1'b0, 1};
    vecs[6] = '{CMul,  64'd2,   64'd2,  0,   1'b1, 64'hdeadbeefdeadbeef, 127, 1'b1, 127};
    vecs[7] = '{CDivw, 64'd9,   64'd3,  127, 1'b0, 64'd3,  127, 1'b0, 127};
    vecs[8] = '{CXor,  64'hf0,  64'hff, 0,   1'b0, 64'h0f, 1,   1'b0, 0};
    ops = '{CAdd, CSub, CAnd, COr, CXor, CMul, CMulw, CDiv, CDivu, CRem, CRemu,
            CDivw, CDivuw, CRemw, CRemuw};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_ctrl = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst alu_en", alu_en, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_result", out_result, 64'd0);
    chk("rst out_tag", out_tag, 8'd0);
    chk("rst out_lat", out_lat, 8'd0);
    chk("rst out_err", out_err, 1'b0);
    chk("rst alu_a", alu_a, 64'd0);
    chk("rst alu_ctrl", alu_ctrl, 5'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], 8'(i + 1));

    // Backpressure: ADD result held while SUB waits; drain and accept in the same cycle.
    alu_k = 1; out_ready = 1'b0;
    in_a = 64'd5; in_b = 64'd6; in_ctrl = CAdd; in_tag = 8'h21; in_valid = 1'b1;
    @(negedge clk);
    chk("bp first accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_a = 64'd20; in_b = 64'd8; in_ctrl = CSub; in_tag = 8'h22;
    @(negedge clk);
    chk("bp run no valid", out_valid, 1'b0);
    chk("bp run in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp stall in_ready", in_ready, 1'b0);
      chk("bp held valid", out_valid, 1'b1);
      chk("bp held result", out_result, 64'd11);
      chk("bp held tag", out_tag, 8'h21);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp drain accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp sub run no valid", out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp sub valid", out_valid, 1'b1);
    chk("bp sub result", out_result, 64'd12);
    chk("bp sub tag", out_tag, 8'h22);
    chk("bp sub lat", out_lat, 8'd1);
    @(posedge clk); #1;

    // Flush on the 10th RUN cycle of a long REMU.
    alu_k = 40;
    in_a = 64'd100; in_b = 64'd7; in_ctrl = CRemu; in_tag = 8'h31; in_valid = 1'b1;
    @(negedge clk);
    chk("fl accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("fl en before", alu_en, 1'b1);
    chk("fl in_ready during", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl gap en", alu_en, 1'b0);
    chk("fl gap busy", busy, 1'b1);
    chk("fl gap in_ready", in_ready, 1'b0);
    chk("fl gap valid", out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl idle in_ready", in_ready, 1'b1);
    chk("fl idle busy", busy, 1'b0);
    ov_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) ov_bad++;
    end
    chk("fl no output", ov_bad, 0);
    @(posedge clk); #1;

    // Reset pulsed during a MULW RUN.
    alu_k = 30;
    in_a = 64'd3; in_b = 64'd5; in_ctrl = CMulw; in_tag = 8'h41; in_valid = 1'b1;
    @(negedge clk);
    chk("rr accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rr en running", alu_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rr alu_en", alu_en, 1'b0);
    chk("rr busy", busy, 1'b0);
    chk("rr out_valid", out_valid, 1'b0);
    chk("rr alu_a", alu_a, 64'd0);
    chk("rr alu_ctrl", alu_ctrl, 5'd0);
    chk("rr out_result", out_result, 64'd0);
    chk("rr in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    run_vec('{CAdd, 64'd1, 64'd1, 0, 1'b0, 64'd2, 1, 1'b0, 0}, 8'h42);

    // Randomized traffic against a transaction-level scoreboard.
    in_valid = 1'b0; pend_k = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_ctrl  = ops[$urandom_range(0, 14)];
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom | 32'd1};
        in_tag   = 8'($urandom);
        pend_k   = $urandom_range(1, 12);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd spurious valid", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("rnd result", out_result, e.res);
          chk("rnd tag", out_tag, e.tag);
          chk("rnd lat", out_lat, e.lat);
          chk("rnd err", out_err, 1'b0);
        end
      end
      acc = in_valid && in_ready;
      if (acc) sb.push_back('{alu_fn(in_ctrl, in_a, in_b), in_tag,
                              is_mc(in_ctrl) ? 8'(pend_k) : 8'd1});
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        alu_k    = pend_k;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rnd drain result", out_result, e.res);
        chk("rnd drain tag", out_tag, e.tag);
      end
      @(posedge clk); #1;
    end
    chk("rnd scoreboard empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
